// File: rtl/unidade_controle_jogada_if.sv
// rtl/unidade_controle_jogada_if.sv - strobe/status bundle between the play control unit and its datapath
//
// Purpose: groups the datapath control strobes and the datapath status flags.
//   master : control unit side (drives strobes, reads flags)
//   slave  : datapath side (reads strobes, drives flags)
// Signals:
//   zeraC              counter synchronous clear
//   contaC             counter enable
//   zeraR              key register clear
//   registraR          key register load
//   chavesIgualMemoria comparator equal flag (debug only)
//   fimC               counter terminal count (address 15)
//   fimDiferente       comparator mismatch flag
interface unidade_controle_jogada_if;
  logic zeraC;
  logic contaC;
  logic zeraR;
  logic registraR;
  logic chavesIgualMemoria;
  logic fimC;
  logic fimDiferente;

  modport master (
    output zeraC, contaC, zeraR, registraR,
    input  chavesIgualMemoria, fimC, fimDiferente
  );

  modport slave (
    input  zeraC, contaC, zeraR, registraR,
    output chavesIgualMemoria, fimC, fimDiferente
  );
endinterface

// File: rtl/unidade_controle_jogada.sv
// rtl/unidade_controle_jogada.sv - control unit sequencing one round of plays over the game datapath
//
// Purpose: clears the datapath, waits for a play (rising edge of jogada), loads the
// keys, checks the comparison flags and advances the address, ending the round on
// the first mismatch or after 16 matching positions.
// Optional feature: define UNIDADE_CONTROLE_TIMEOUT_EN to end the round when no
// play arrives within TIMEOUT_CYCLES cycles in ESPERA.
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low
//   iniciar    start/restart request (level)
//   jogada     play indication (OR of keys)
//   dp         datapath strobes/flags (master modport)
//   pronto     round finished
//   acertou    round finished with all 16 matches
//   errou      round finished on mismatch
//   timeout    round finished by timeout (0 unless the timeout feature is built)
//   db_estado  current state code for the debug display
module unidade_controle_jogada #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic                       jogada,
  unidade_controle_jogada_if.master  dp,
  output logic                       pronto,
  output logic                       acertou,
  output logic                       errou,
  output logic                       timeout,
  output logic [3:0]                 db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hB,
    FIM_ERROU   = 4'hE
  } state_t;

  state_t state;
  state_t state_next;

  // Reset value 1 so a key already held when reset is released is not a play.
  logic jogada_d;
  logic jogada_edge;
  assign jogada_edge = jogada & ~jogada_d;

  logic espera_expirou;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] ESPERA_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] espera_cnt;
  assign espera_expirou = (espera_cnt == ESPERA_LAST);

  // Counts cycles spent in ESPERA; zero whenever the next cycle is not a
  // continued stay, so every fresh entry starts from 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      espera_cnt <= '0;
    end else if (state == ESPERA && state_next == ESPERA) begin
      espera_cnt <= espera_cnt + 1'b1;
    end else begin
      espera_cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= (state_next == FIM_TIMEOUT);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign espera_expirou = 1'b0;
  assign timeout        = 1'b0;
`endif

  // Comparator equal flag is only carried for top-level wiring.
  logic unused_igual;
  assign unused_igual = dp.chavesIgualMemoria;

  always_comb begin
    state_next = state;
    case (state)
      INICIAL:    if (iniciar) state_next = PREPARACAO;
      PREPARACAO: state_next = ESPERA;
      // A play on the last allowed cycle wins over the timeout.
      ESPERA: begin
        if (jogada_edge)         state_next = REGISTRA;
        else if (espera_expirou) state_next = FIM_TIMEOUT;
      end
      REGISTRA:   state_next = COMPARACAO;
      COMPARACAO: begin
        if (dp.fimDiferente) state_next = FIM_ERROU;
        else if (dp.fimC)    state_next = FIM_ACERTOU;
        else                 state_next = PROXIMO;
      end
      PROXIMO:    state_next = ESPERA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (iniciar) state_next = PREPARACAO;
      end
      default:    state_next = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they follow the state
  // register exactly while being glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= INICIAL;
      jogada_d     <= 1'b1;
      dp.zeraC     <= 1'b0;
      dp.zeraR     <= 1'b0;
      dp.contaC    <= 1'b0;
      dp.registraR <= 1'b0;
      pronto       <= 1'b0;
      acertou      <= 1'b0;
      errou        <= 1'b0;
    end else begin
      state        <= state_next;
      jogada_d     <= jogada;
      dp.zeraC     <= (state_next == PREPARACAO);
      dp.zeraR     <= (state_next == PREPARACAO);
      dp.contaC    <= (state_next == PROXIMO);
      dp.registraR <= (state_next == REGISTRA);
      pronto       <= (state_next == FIM_ACERTOU) || (state_next == FIM_ERROU) ||
                      (state_next == FIM_TIMEOUT);
      acertou      <= (state_next == FIM_ACERTOU);
      errou        <= (state_next == FIM_ERROU);
    end
  end

  assign db_estado = state;

endmodule

// File: tb/tb_unidade_controle_jogada.sv
// tb/tb_unidade_controle_jogada.sv - self-checking bench for the play control unit
module tb_unidade_controle_jogada;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int failures = 0;

  unidade_controle_jogada_if bus ();

  unidade_controle_jogada #(.TIMEOUT_CYCLES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .dp        (bus),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // Behavioural datapath: address counter, key register, memory and comparator.
  logic [3:0] mem [16];
  logic [3:0] keys [16];
  logic [3:0] keys_cur = 4'h0;
  logic [3:0] addr = 4'h0;
  logic [3:0] keyreg = 4'h0;

  always @(posedge clock) begin
    if (bus.zeraC)       addr <= 4'h0;
    else if (bus.contaC) addr <= addr + 4'h1;
    if (bus.zeraR)          keyreg <= 4'h0;
    else if (bus.registraR) keyreg <= keys_cur;
  end

  assign bus.fimC               = (addr == 4'd15);
  assign bus.fimDiferente       = (keyreg != mem[addr]);
  assign bus.chavesIgualMemoria = (keyreg == mem[addr]);

  // Strobe pulse counters (cycles with the strobe high).
  int n_registra = 0;
  int n_conta = 0;
  int n_zera = 0;
  always @(posedge clock) begin
    if (bus.registraR === 1'b1)                     n_registra <= n_registra + 1;
    if (bus.contaC === 1'b1)                        n_conta <= n_conta + 1;
    if (bus.zeraC === 1'b1 && bus.zeraR === 1'b1)   n_zera <= n_zera + 1;
  end

  task automatic wait_state(input logic [3:0] code, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (db_estado === code) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic start_round();
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // One full round; mis_idx < 0 means all positions match.
  task automatic run_round(input int mis_idx);
    int  n_exp;
    bit  mism;
    bit  ok;
    int  base_r, base_c;
    logic [3:0] fin_exp;
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 4'($urandom_range(0, 15));
      keys[i] = mem[i];
      if (i == mis_idx) keys[i] = mem[i] ^ 4'($urandom_range(1, 15));
    end
    n_exp = 16;
    mism  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (keys[i] != mem[i]) begin
        n_exp = i + 1;
        mism  = 1'b1;
        break;
      end
    end
    fin_exp = mism ? 4'hE : 4'hA;
    base_r = n_registra;
    base_c = n_conta;
    start_round();
    for (int p = 0; p < 16; p++) begin
      wait_state(4'h2, 20, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL round_wait_espera play=%0d got=%h want=2", p, db_estado);
        break;
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      keys_cur = keys[p];
      jogada = 1'b1;
      @(negedge clock);
      checks++;
      if (db_estado !== 4'h4 || bus.registraR !== 1'b1) begin
        failures++;
        $display("FAIL round_registra play=%0d got=%h/%b want=4/1", p, db_estado, bus.registraR);
      end
      @(negedge clock);
      checks++;
      if (db_estado !== 4'h5) begin
        failures++;
        $display("FAIL round_comparacao play=%0d got=%h want=5", p, db_estado);
      end
      jogada = 1'b0;
      @(negedge clock);
      if (db_estado !== 4'h6) break;
    end
    checks++;
    if (db_estado !== fin_exp) begin
      failures++;
      $display("FAIL round_final_state got=%h want=%h", db_estado, fin_exp);
    end
    checks++;
    if ({pronto, acertou, errou, timeout} !== {1'b1, ~mism, mism, 1'b0}) begin
      failures++;
      $display("FAIL round_flags got=%b want=%b", {pronto, acertou, errou, timeout},
               {1'b1, ~mism, mism, 1'b0});
    end
    checks++;
    if (n_registra - base_r !== n_exp) begin
      failures++;
      $display("FAIL round_registra_count got=%0d want=%0d", n_registra - base_r, n_exp);
    end
    checks++;
    if (n_conta - base_c !== n_exp - 1) begin
      failures++;
      $display("FAIL round_conta_count got=%0d want=%0d", n_conta - base_c, n_exp - 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({db_estado, pronto, acertou, errou, timeout,
         bus.zeraC, bus.zeraR, bus.contaC, bus.registraR} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b want=0/all zero", db_estado,
               {pronto, acertou, errou, timeout, bus.zeraC, bus.zeraR, bus.contaC, bus.registraR});
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (db_estado !== 4'h0 || bus.zeraC !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got=%h want=0", db_estado);
    end
  endtask

  task automatic test_start();
    int base_z;
    base_z = n_zera;
    iniciar = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h1 || bus.zeraC !== 1'b1 || bus.zeraR !== 1'b1) begin
      failures++;
      $display("FAIL start_preparacao got=%h/%b%b want=1/11", db_estado, bus.zeraC, bus.zeraR);
    end
    iniciar = 1'b0;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h2 || bus.zeraC !== 1'b0) begin
      failures++;
      $display("FAIL start_espera got=%h/%b want=2/0", db_estado, bus.zeraC);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (n_zera - base_z !== 1) begin
      failures++;
      $display("FAIL start_zera_pulses got=%0d want=1", n_zera - base_z);
    end
  endtask

  task automatic test_jogada_held_reset();
    int base_r;
    for (int i = 0; i < 16; i++) mem[i] = 4'h3;
    keys_cur = 4'h3;
    jogada = 1'b1;
    do_reset();
    start_round();
    base_r = n_registra;
    repeat (4) @(negedge clock);
    checks++;
    if (db_estado !== 4'h2) begin
      failures++;
      $display("FAIL held_no_play got=%h want=2", db_estado);
    end
    jogada = 1'b0;
    @(negedge clock);
    jogada = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h4) begin
      failures++;
      $display("FAIL held_new_edge got=%h want=4", db_estado);
    end
    repeat (6) @(negedge clock);
    checks++;
    if (n_registra - base_r !== 1 || db_estado !== 4'h2) begin
      failures++;
      $display("FAIL held_single_play got=%0d/%h want=1/2", n_registra - base_r, db_estado);
    end
  endtask

  task automatic test_fast_edges();
    int base_r;
    keys_cur = mem[addr];
    jogada = 1'b0;
    @(negedge clock);
    base_r = n_registra;
    jogada = 1'b1;
    @(negedge clock);
    jogada = 1'b0;
    @(negedge clock);
    jogada = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (n_registra - base_r !== 1 || db_estado !== 4'h2) begin
      failures++;
      $display("FAIL fast_edge_dropped got=%0d/%h want=1/2", n_registra - base_r, db_estado);
    end
    jogada = 1'b0;
  endtask

  task automatic test_round();
    do_reset();
    run_round(-1);
    run_round(2);
    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(0, 2) == 0) run_round(-1);
      else run_round(int'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_iniciar_held();
    int base_z;
    do_reset();
    run_round(0);
    base_z = n_zera;
    iniciar = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h1) begin
      failures++;
      $display("FAIL iniciar_restart got=%h want=1", db_estado);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (db_estado !== 4'h2 || n_zera - base_z !== 1) begin
      failures++;
      $display("FAIL iniciar_held_once got=%h/%0d want=2/1", db_estado, n_zera - base_z);
    end
    iniciar = 1'b0;
  endtask

  task automatic test_reset_mid();
    keys_cur = mem[addr];
    @(negedge clock);
    jogada = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h5) begin
      failures++;
      $display("FAIL mid_in_comparacao got=%h want=5", db_estado);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({db_estado, pronto, acertou, errou, timeout,
         bus.zeraC, bus.zeraR, bus.contaC, bus.registraR} !== 12'h000) begin
      failures++;
      $display("FAIL mid_async_reset got=%h/%b want=0/all zero", db_estado,
               {pronto, acertou, errou, timeout, bus.zeraC, bus.zeraR, bus.contaC, bus.registraR});
    end
    jogada = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_round(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 15)));
  endtask

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  task automatic test_timeout();
    jogada = 1'b0;
    start_round();
    repeat (7) @(negedge clock);
    checks++;
    if (db_estado !== 4'h2) begin
      failures++;
      $display("FAIL timeout_early got=%h want=2", db_estado);
    end
    @(negedge clock);
    checks++;
    if ({db_estado, pronto, acertou, errou, timeout} !== {4'hB, 4'b1001}) begin
      failures++;
      $display("FAIL timeout_fim got=%h/%b want=b/1001", db_estado, {pronto, acertou, errou, timeout});
    end
    start_round();
    repeat (7) @(negedge clock);
    jogada = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h4 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_edge_wins got=%h/%b want=4/0", db_estado, timeout);
    end
    jogada = 1'b0;
    repeat (3) @(negedge clock);
  endtask
`else
  task automatic test_timeout();
    jogada = 1'b0;
    start_round();
    repeat (20) @(negedge clock);
    checks++;
    if (db_estado !== 4'h2 || timeout !== 1'b0 || pronto !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_wait got=%h/%b%b want=2/00", db_estado, timeout, pronto);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 4'h0;
      keys[i] = 4'h0;
    end
    test_reset();
    test_start();
    test_jogada_held_reset();
    test_fast_edges();
    test_round();
    test_iniciar_held();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/unidade_controle_jogada.md
# unidade_controle_jogada

- Control unit that sequences the game datapath through one full round: clear, wait for a play, register the keys, compare against memory, advance the address.
- Drives the datapath strobes (`zeraC`, `contaC`, `zeraR`, `registraR`) and consumes its status flags (`chavesIgualMemoria`, `fimC`, `fimDiferente`).
- Sits directly above the datapath in the experiment top level. Ends the round on the first mismatch, or after all 16 positions match.

## Interface
- `TIMEOUT_CYCLES`, default 5000: idle cycles allowed in ESPERA before timeout (only used with `TIMEOUT_EN`).
- `clock` in 1: system clock, all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low. Forces INICIAL immediately.
- `iniciar` in 1: start/restart request, level-sampled.
- `jogada` in 1: play indication (OR of key inputs). Rising edge detected internally.
- `chavesIgualMemoria` in 1: datapath comparator equal flag.
- `fimC` in 1: datapath counter terminal count (address 15).
- `fimDiferente` in 1: datapath mismatch flag.
- `zeraC` out 1: synchronous counter clear.
- `contaC` out 1: counter enable.
- `zeraR` out 1: key register clear.
- `registraR` out 1: key register load.
- `pronto` out 1: round finished.
- `acertou` out 1: round finished with all 16 matches.
- `errou` out 1: round finished on mismatch.
- `timeout` out 1: round finished by timeout. Constant 0 without `TIMEOUT_EN`.
- `db_estado` out 4: current state code, for the 7-segment debug display.

## Operation
- State codes: INICIAL 0x0, PREPARACAO 0x1, ESPERA 0x2, REGISTRA 0x4, COMPARACAO 0x5, PROXIMO 0x6, FIM_ACERTOU 0xA, FIM_TIMEOUT 0xB, FIM_ERROU 0xE.
- INICIAL: no outputs asserted. Goes to PREPARACAO when `iniciar`=1.
- PREPARACAO: `zeraC`=1, `zeraR`=1. Always goes to ESPERA.
- ESPERA: waits for a `jogada` edge, which moves it to REGISTRA. Otherwise stays.
- REGISTRA: `registraR`=1. Always goes to COMPARACAO.
- COMPARACAO: exits by priority:
  - `fimDiferente`=1 → FIM_ERROU;
  - else `fimC`=1 → FIM_ACERTOU;
  - else → PROXIMO.
- PROXIMO: `contaC`=1. Always goes to ESPERA.
- FIM_* states:
  - `pronto`=1, plus the matching `acertou`, `errou` or `timeout` held at 1;
  - `iniciar`=1 goes to PREPARACAO (new round), otherwise stay.
- All outputs are Moore, decoded from the state register only. At most one of `acertou`/`errou`/`timeout` is ever 1.
- Edge detector:
  - `jogada_d` register, reset value 1, so a level held across reset is not a play;
  - edge = `jogada` & ~`jogada_d`;
  - edges outside ESPERA are discarded, never queued.
- `chavesIgualMemoria` is not used for decisions; it is carried for debug and top-level wiring only.

## Timing
- Reset (asynchronous): state INICIAL, `jogada_d`=1, timeout counter 0, all outputs 0, `db_estado`=0x0.
- Latency from `jogada` edge to end of compare:
  - edge sampled in ESPERA at edge N;
  - REGISTRA during cycle N..N+1, key register loads at edge N+1;
  - COMPARACAO during N+1..N+2, with registered keys and ROM data both stable;
  - exit at edge N+2.
- Sync ROM: the address advances at the end of PROXIMO, and data is valid one edge later, which is before any following COMPARACAO. No wait state is needed.
- Minimum play spacing is 4 cycles (ESPERA→REGISTRA→COMPARACAO→PROXIMO→ESPERA). `jogada` edges arriving faster are dropped.
- `iniciar` held high across a FIM state restarts once, then is ignored until the next FIM or INICIAL.
- Reset asserted mid-round aborts immediately. No datapath strobe is issued during reset.

## Configuration
- Macro `UNIDADE_CONTROLE_TIMEOUT_EN`, when defined:
  - counter of width ceil(log2(`TIMEOUT_CYCLES`)), 0 outside ESPERA, +1 each cycle in ESPERA;
  - when it equals `TIMEOUT_CYCLES`-1 and no `jogada` edge occurs that cycle, go to FIM_TIMEOUT (`pronto`=1, `timeout`=1);
  - if a `jogada` edge occurs on that same cycle, the edge wins and the state goes to REGISTRA;
  - the counter clears on each re-entry to ESPERA.
- When undefined: no counter, state 0xB is unreachable, `timeout` is tied to 0, and ESPERA waits indefinitely.

## Test plan
- Reset, then `iniciar` pulse:
  - `db_estado` 0x0 → 0x1 → 0x2;
  - `zeraC`=`zeraR`=1 for exactly one cycle.
- 16 plays with `fimDiferente`=0, and `fimC`=1 only on the 16th compare:
  - exactly 16 `registraR` pulses and 15 `contaC` pulses;
  - ends in 0xA with `pronto`=`acertou`=1.
- 3rd play with `fimDiferente`=1:
  - 3 `registraR` pulses and 2 `contaC` pulses;
  - `db_estado`=0xE, `errou`=1, `acertou`=0.
- `jogada` held high through reset release and into ESPERA: no transition. Drop to 0 then raise to 1: exactly one REGISTRA.
- `TIMEOUT_EN` with `TIMEOUT_CYCLES`=8, no play:
  - FIM_TIMEOUT 8 cycles after entering ESPERA;
  - an edge on the 8th cycle goes to REGISTRA instead.
- Reset pulsed low while in COMPARACAO: outputs 0 asynchronously, and a new `iniciar` runs a clean round.
